// File: rtl/fir_ctrl_pkg.sv
// Shared types and default widths for the FIR coefficient sequencer.
// The readback verify feature is enabled by defining FIR_READBACK_VERIFY_EN.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    VERIFY = 3'd3,
    RUN    = 3'd4
  } state_t;

  localparam int DEF_NUM_TAPS = 16;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_COEF_W   = 12;
  localparam int DEF_DATA_W   = 12;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_seq_counter.sv
// Clearable, enabled up-counter with terminal-count compare, shared by the
// LOAD, FLUSH and VERIFY phases of the sequencer.
module fir_seq_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Loads a coefficient stream into the FIR tap RAM, flushes the delay line and
// then gates samples into the FIR. Readback verify: FIR_READBACK_VERIFY_EN.
module fir_coeff_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cfg_start,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] fir_din,
  output logic [ADDR_W-1:0] fir_write_address,
  output logic [COEF_W-1:0] fir_write_value,
  output logic              fir_load,
  output logic [ADDR_W-1:0] fir_read_address,
  input  logic [COEF_W-1:0] fir_read_value,
  output logic              busy,
  output logic              run,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_acc;
  logic              w_clear;
  logic              w_en;
  logic              w_tc;
  logic [ADDR_W-1:0] w_count;
  logic [ADDR_W-1:0] w_last;
  logic              w_start_ok;

  logic              r_load;
  logic [ADDR_W-1:0] r_waddr;
  logic [COEF_W-1:0] r_wval;
  logic [DATA_W-1:0] r_din;
  logic              r_done;

  assign w_acc      = coef_valid && (r_state == LOAD);
  assign w_start_ok = cfg_start && ((r_state == IDLE) || (r_state == RUN));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (cfg_start) w_next = LOAD;
      LOAD:   if (w_acc && w_tc) w_next = FLUSH;
`ifdef FIR_READBACK_VERIFY_EN
      FLUSH:  if (w_tc) w_next = VERIFY;
      VERIFY: if (w_tc) w_next = RUN;
`else
      FLUSH:  if (w_tc) w_next = RUN;
`endif
      RUN:    if (cfg_start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  // The counter restarts from zero on every state change.
  assign w_clear = (w_next != r_state);

  always_comb begin
    w_en   = 1'b0;
    w_last = LAST_IDX;
    case (r_state)
      LOAD:   w_en = w_acc;
      FLUSH:  w_en = 1'b1;
`ifdef FIR_READBACK_VERIFY_EN
      VERIFY: begin
        w_en   = 1'b1;
        w_last = ADDR_W'(NUM_TAPS);
      end
`endif
      default: w_en = 1'b0;
    endcase
  end

  fir_seq_counter #(
    .W (ADDR_W)
  ) u_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clear (w_clear),
    .i_en    (w_en),
    .i_last  (w_last),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_load  <= 1'b0;
      r_waddr <= '0;
      r_wval  <= '0;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_load <= w_acc;
      if (w_acc) begin
        r_waddr <= w_count;
        r_wval  <= coef_data;
      end
      r_din  <= ((r_state == RUN) && din_valid) ? din : '0;
      r_done <= (w_next == RUN) && (r_state != RUN);
    end
  end

  assign coef_ready        = (r_state == LOAD);
  assign busy              = (r_state != IDLE) && (r_state != RUN);
  assign run               = (r_state == RUN);
  assign cfg_done          = r_done;
  assign fir_load          = r_load;
  assign fir_write_address = r_waddr;
  assign fir_write_value   = r_wval;
  assign fir_din           = r_din;

`ifdef FIR_READBACK_VERIFY_EN
  localparam int IDX_W = idx_w(NUM_TAPS);

  logic [COEF_W-1:0] r_shadow [NUM_TAPS];
  logic              w_rd_ok;
  logic              r_chk;
  logic [IDX_W-1:0]  r_chk_idx;
  logic              r_err;

  assign w_rd_ok          = (r_state == VERIFY) && (w_count <= LAST_IDX);
  assign fir_read_address = w_rd_ok ? w_count : '0;

  always_ff @(posedge Clk) begin
    if (w_acc) begin
      r_shadow[w_count[IDX_W-1:0]] <= coef_data;
    end
  end

  // Read data returns one cycle after the address, so the compare index is delayed to match.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_chk     <= 1'b0;
      r_chk_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_chk     <= w_rd_ok;
      r_chk_idx <= w_count[IDX_W-1:0];
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (r_chk && (fir_read_value != r_shadow[r_chk_idx])) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cfg_err = r_err;
`else
  logic w_unused_rd;

  assign w_unused_rd      = ^{fir_read_value, w_start_ok};
  assign fir_read_address = '0;
  assign cfg_err          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Randomized scoreboard bench for fir_coeff_sequencer with a transaction-level
// phase model and a small tap-RAM model answering readback requests.
module tb_fir_coeff_sequencer;

  localparam int NUM_TAPS = 16;
  localparam int ADDR_W   = 8;
  localparam int COEF_W   = 12;
  localparam int DATA_W   = 12;
  localparam int MAXC     = 8192;
`ifdef FIR_READBACK_VERIFY_EN
  localparam bit VERIFY   = 1'b1;
`else
  localparam bit VERIFY   = 1'b0;
`endif
  localparam int BUSY_LEN = VERIFY ? (2 * NUM_TAPS + 1) : NUM_TAPS;

  localparam int P_IDLE = 0, P_LOAD = 1, P_BUSY = 2, P_RUN = 3;

  typedef struct {
    int cyc;
    int addr;
    int val;
  } ev_t;

  logic              Clk = 1'b0;
  logic              Reset, cfg_start, coef_valid, din_valid;
  logic [COEF_W-1:0] coef_data;
  logic [DATA_W-1:0] din;
  logic              coef_ready, fir_load, busy, run, cfg_done, cfg_err;
  logic [DATA_W-1:0] fir_din;
  logic [ADDR_W-1:0] fir_write_address, fir_read_address;
  logic [COEF_W-1:0] fir_write_value, fir_read_value;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_phase = P_IDLE;
  int m_beats = 0;
  int m_rem = 0;
  bit m_err = 1'b0;
  bit m_corrupt = 1'b0;
  int phase_arr [MAXC];
  bit err_arr [MAXC];
  ev_t wq[$];
  ev_t sq[$];
  int  dq[$];
  logic [COEF_W-1:0] vals [NUM_TAPS];
  logic [COEF_W-1:0] ram [NUM_TAPS];

  fir_coeff_sequencer #(
    .NUM_TAPS (NUM_TAPS),
    .ADDR_W   (ADDR_W),
    .COEF_W   (COEF_W),
    .DATA_W   (DATA_W)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .cfg_start         (cfg_start),
    .coef_valid        (coef_valid),
    .coef_data         (coef_data),
    .coef_ready        (coef_ready),
    .din_valid         (din_valid),
    .din               (din),
    .fir_din           (fir_din),
    .fir_write_address (fir_write_address),
    .fir_write_value   (fir_write_value),
    .fir_load          (fir_load),
    .fir_read_address  (fir_read_address),
    .fir_read_value    (fir_read_value),
    .busy              (busy),
    .run               (run),
    .cfg_done          (cfg_done),
    .cfg_err           (cfg_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Tap RAM stand-in: one-cycle read latency, optional single-bit fault at address 5.
  always @(posedge Clk) begin
    if (fir_load) ram[fir_write_address[3:0]] <= fir_write_value;
    fir_read_value <= ram[fir_read_address[3:0]] ^
                      ((m_corrupt && fir_read_address == 8'd5) ? 12'h001 : 12'h000);
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Advances the reference model by one cycle using the inputs currently driven.
  task automatic model_step();
    int n;
    n = cyc;
    if (Reset) begin
      m_phase = P_IDLE;
      m_beats = 0;
      m_err   = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (cfg_start) begin
          m_phase = P_LOAD;
          m_beats = 0;
          m_err   = 1'b0;
        end
        P_LOAD: if (coef_valid) begin
          wq.push_back('{n + 1, m_beats, int'(coef_data)});
          m_beats++;
          if (m_beats == NUM_TAPS) begin
            m_phase = P_BUSY;
            m_rem   = BUSY_LEN;
          end
        end
        P_BUSY: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = P_RUN;
            dq.push_back(n + 1);
            if (VERIFY && m_corrupt) m_err = 1'b1;
          end
        end
        default: begin
          if (din_valid) sq.push_back('{n + 1, 0, int'(din)});
          if (cfg_start) begin
            m_phase = P_LOAD;
            m_beats = 0;
            m_err   = 1'b0;
          end
        end
      endcase
    end
    phase_arr[(n + 1) % MAXC] = m_phase;
    err_arr[(n + 1) % MAXC]   = m_err;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_din();
    din_valid = 1'($urandom_range(0, 1));
    din       = DATA_W'($urandom_range(1, 4095));
  endtask

  task automatic do_load(input int mode, input bit seq, input int abort_at);
    int guard;
    guard = 0;
    for (int i = 0; i < NUM_TAPS; i++)
      vals[i] = seq ? COEF_W'(i + 1) : COEF_W'($urandom_range(0, 4095));
    cfg_start = 1'b1;
    din_valid = 1'b1;
    din       = DATA_W'($urandom_range(1, 4095));
    tick();
    cfg_start = 1'b0;
    while (m_phase == P_LOAD && guard < 400) begin
      if (abort_at >= 0 && m_beats == abort_at) begin
        Reset      = 1'b1;
        coef_valid = 1'b1;
        tick();
        Reset      = 1'b0;
        coef_valid = 1'b0;
        return;
      end
      case (mode)
        0:       coef_valid = 1'b1;
        1:       coef_valid = (guard % 2 == 0);
        default: coef_valid = 1'($urandom_range(0, 1));
      endcase
      coef_data = vals[m_beats];
      rand_din();
      tick();
      guard++;
    end
    coef_valid = 1'b0;
    check(guard < 400, "load_timeout", guard, 400);
  endtask

  task automatic wait_run();
    int guard;
    guard = 0;
    while (m_phase != P_RUN && guard < 200) begin
      cfg_start = (guard == 3);
      rand_din();
      tick();
      guard++;
    end
    cfg_start = 1'b0;
    check(guard < 200, "run_timeout", guard, 200);
  endtask

  task automatic run_traffic(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i == 2) begin
        din_valid = 1'b1;
        din       = DATA_W'(100);
      end else if (i == 3) begin
        din_valid = 1'b0;
      end else begin
        rand_din();
      end
      tick();
    end
  endtask

  always @(negedge Clk) begin
    int  p;
    bit  [2:0] exp3;
    ev_t e;
    if (cyc >= 1) begin
      p = phase_arr[cyc % MAXC];
      exp3 = (p == P_LOAD) ? 3'b110 : (p == P_BUSY) ? 3'b010 : (p == P_RUN) ? 3'b001 : 3'b000;
      check({coef_ready, busy, run} == exp3, "ready_busy_run", {coef_ready, busy, run}, exp3);
      if (p != P_BUSY) check(cfg_err == err_arr[cyc % MAXC], "cfg_err", cfg_err, err_arr[cyc % MAXC]);
      if (cyc == 1) begin
        check({fir_write_address, fir_write_value, fir_read_address} == '0, "reset_outputs",
              {fir_write_address, fir_write_value, fir_read_address}, 0);
      end

      if (fir_load) begin
        if (wq.size() == 0) begin
          check(1'b0, "write_unexpected", fir_write_address, -1);
        end else begin
          e = wq.pop_front();
          check(e.cyc == cyc, "write_time", cyc, e.cyc);
          check(fir_write_address == e.addr, "write_addr", fir_write_address, e.addr);
          check(fir_write_value == e.val, "write_value", fir_write_value, e.val);
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        e = wq.pop_front();
        check(1'b0, "write_missing", 0, e.cyc);
      end

      if (fir_din != '0) begin
        if (sq.size() == 0) begin
          check(1'b0, "sample_unexpected", fir_din, 0);
        end else begin
          e = sq.pop_front();
          check(e.cyc == cyc, "sample_time", cyc, e.cyc);
          check(fir_din == e.val, "sample_value", fir_din, e.val);
        end
      end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
        e = sq.pop_front();
        check(1'b0, "sample_missing", 0, e.val);
      end

      if (cfg_done) begin
        if (dq.size() == 0) check(1'b0, "done_unexpected", cyc, -1);
        else check(dq.pop_front() == cyc, "done_time", cyc, cyc);
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        check(1'b0, "done_missing", cyc, dq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; cfg_start = 1'b0; coef_valid = 1'b0; coef_data = '0;
    din_valid = 1'b0; din = '0;
    tick();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_din();
      tick();
    end

    do_load(0, 1'b1, -1);
    wait_run();
    run_traffic(30);

    do_load(1, 1'b0, -1);
    wait_run();
    run_traffic(20);

    do_load(2, 1'b0, 7);
    for (int i = 0; i < 3; i++) begin
      rand_din();
      tick();
    end
    do_load(2, 1'b0, -1);
    wait_run();
    run_traffic(20);

    m_corrupt = 1'b1;
    do_load(0, 1'b0, -1);
    wait_run();
    run_traffic(10);
    m_corrupt = 1'b0;
    do_load(2, 1'b0, -1);
    wait_run();
    run_traffic(10);

    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check(wq.size() + sq.size() + dq.size() == 0, "queues_drained",
          wq.size() + sq.size() + dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
